// File: rtl/register_scoreboard.sv
// register_scoreboard
// ----------------------------------------------------------------------------
// Purpose:
//   This is a per-thread register scoreboard that sits between thread select
//   and operand fetch. For every hardware thread it records which of the 64
//   registers (32 scalar + 32 vector) have a write in flight. Each cycle it
//   answers one combinational RAW/WAW hazard query and clears entries on
//   writeback. A short issue history lets a rollback unwind only the
//   destinations issued inside the squash window.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   q_*               hazard query (thread, up to 3 sources, 1 destination)
//   q_ready           combinational: nothing the query touches is pending
//   issue_*           instruction issued this cycle (sets its destination)
//   wb_*              register writeback (clears a pending bit)
//   rollback_*        squash the recent issues of one thread
//   thread_idle       registered: bit t = thread t has no pending registers
//
// Register index encoding is {is_vector, reg[4:0]}.
// ----------------------------------------------------------------------------
module register_scoreboard #(
    parameter int THREADS         = 4,
    parameter int ROLLBACK_STAGES = 4,
    localparam int TW             = (THREADS > 1) ? $clog2(THREADS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [TW-1:0]      q_thread,
    input  logic               q_src1_valid,
    input  logic               q_src2_valid,
    input  logic               q_src3_valid,
    input  logic [5:0]         q_src1,
    input  logic [5:0]         q_src2,
    input  logic [5:0]         q_src3,
    input  logic               q_dest_valid,
    input  logic [5:0]         q_dest,
    output logic               q_ready,
    input  logic               issue_en,
    input  logic [TW-1:0]      issue_thread,
    input  logic               issue_dest_valid,
    input  logic [5:0]         issue_dest,
    input  logic               wb_en,
    input  logic [TW-1:0]      wb_thread,
    input  logic               wb_is_vector,
    input  logic [4:0]         wb_reg,
    input  logic               rollback_en,
    input  logic [TW-1:0]      rollback_thread,
    output logic [THREADS-1:0] thread_idle
);

    typedef struct packed {
        logic          valid;
        logic [TW-1:0] thread;
        logic [5:0]    dest;
    } hist_t;

    logic [63:0]          pending_q [THREADS];
    logic [63:0]          pending_d [THREADS];
    hist_t                hist_q    [ROLLBACK_STAGES];
    hist_t                hist_d    [ROLLBACK_STAGES];
    logic [THREADS-1:0]   thread_idle_q;
    logic [THREADS-1:0]   thread_idle_d;

    logic [63:0]                q_pend_s;
    logic                       squash_s;
    logic                       issue_set_s;
    logic [ROLLBACK_STAGES-1:0] hist_clear_s;

    // Hazard query: OR of the pending bits of every valid operand; no bypass
    // from a same-cycle issue, so only the current state is consulted.
    always_comb begin
        q_pend_s = pending_q[q_thread];
        q_ready  = ~((q_src1_valid & q_pend_s[q_src1]) |
                     (q_src2_valid & q_pend_s[q_src2]) |
                     (q_src3_valid & q_pend_s[q_src3]) |
                     (q_dest_valid & q_pend_s[q_dest]));
    end

    // Next-state: rollback clears, then writeback clears, then issue sets, so
    // a same-cycle issue to a just-written-back bit leaves it pending.
    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            pending_d[t] = pending_q[t];
        end

        // An issue from the thread being rolled back is itself squashed.
        squash_s    = issue_en & rollback_en & (issue_thread == rollback_thread);
        issue_set_s = issue_en & issue_dest_valid & ~squash_s;

        for (int s = 0; s < ROLLBACK_STAGES; s++) begin
            hist_clear_s[s] = rollback_en & hist_q[s].valid &
                              (hist_q[s].thread == rollback_thread);
            pending_d[hist_q[s].thread][hist_q[s].dest] =
                pending_d[hist_q[s].thread][hist_q[s].dest] & ~hist_clear_s[s];
        end

        pending_d[wb_thread][{wb_is_vector, wb_reg}] =
            pending_d[wb_thread][{wb_is_vector, wb_reg}] & ~wb_en;

        pending_d[issue_thread][issue_dest] =
            pending_d[issue_thread][issue_dest] | issue_set_s;

        // History shifts every cycle; rolled-back entries move on invalidated
        // so a later rollback cannot clear a bit that was re-issued since.
        hist_d[0] = '{valid: issue_set_s, thread: issue_thread, dest: issue_dest};
        for (int s = 1; s < ROLLBACK_STAGES; s++) begin
            hist_d[s]       = hist_q[s-1];
            hist_d[s].valid = hist_q[s-1].valid & ~hist_clear_s[s-1];
        end

        for (int t = 0; t < THREADS; t++) begin
            thread_idle_d[t] = (pending_d[t] == 64'd0);
        end
    end

    // State registers; reset discards all pending bits and history at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < THREADS; t++) begin
                pending_q[t] <= 64'd0;
            end
            for (int s = 0; s < ROLLBACK_STAGES; s++) begin
                hist_q[s] <= '0;
            end
            thread_idle_q <= '1;
        end else begin
            for (int t = 0; t < THREADS; t++) begin
                pending_q[t] <= pending_d[t];
            end
            for (int s = 0; s < ROLLBACK_STAGES; s++) begin
                hist_q[s] <= hist_d[s];
            end
            thread_idle_q <= thread_idle_d;
        end
    end

    assign thread_idle = thread_idle_q;

endmodule
